// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   dump_state_t : snapshot stream FSM states
//   calc_aw      : address width derived from the register count
//   field_lo     : low bit of field `idx` in a packed bus of `width`-bit fields
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  localparam int unsigned MinAw = 1;

  function automatic int unsigned calc_aw(input int unsigned size);
    return (size > 2) ? $clog2(size) : MinAw;
  endfunction

  function automatic int unsigned field_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Snapshot stream controller for regfile_mp.
// Detects the rising edge of `halted`, walks idx 0..SIZE-1 under valid/ready
// handshaking and holds dump_done until `halted` drops.
//   clk, rst_b        : clock, asynchronous active-low reset
//   halted            : core halted level
//   dump_ready        : consumer accepts the current beat
//   dump_valid        : current beat valid
//   dump_done         : all beats delivered, held until halted falls
//   dump_idx          : register index of the current beat
//   freeze            : FSM not idle; parent blocks writes and bypass
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned SIZE = 32,
  parameter int unsigned AW   = calc_aw(SIZE)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          halted,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic          dump_done,
  output logic [AW-1:0] dump_idx,
  output logic          freeze
);

  localparam logic [AW-1:0] LastIdx = AW'(SIZE - 1);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          halted_q;
  logic          rise;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      halted_q <= halted;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    rise       = halted & ~halted_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        // A halted drop during DUMP lands here with halted already low,
        // so we leave after exactly one DONE cycle.
        if (!halted) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_idx = idx_q;
  assign freeze   = (state_q != IDLE);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with combinational reads, synchronous
// writes, optional same-cycle write-to-read bypass, optional hardwired zero
// register and a valid/ready snapshot stream started by a rising `halted`.
//   clk, rst_b                  : clock, asynchronous active-low reset
//   rd_num / rd_data            : NREAD packed read ports
//   wr_we / wr_num / wr_data    : NWRITE packed write ports (highest index wins)
//   halted                      : rising edge starts the snapshot
//   dump_valid/ready/idx/data   : snapshot beat stream
//   dump_done                   : snapshot complete, held until halted falls
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SIZE     = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = calc_aw(SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [NREAD*AW-1:0]    rd_num,
  output logic [NREAD*XLEN-1:0]  rd_data,
  input  logic [NWRITE-1:0]      wr_we,
  input  logic [NWRITE*AW-1:0]   wr_num,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   halted,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [AW-1:0]          dump_idx,
  output logic [XLEN-1:0]        dump_data,
  output logic                   dump_done
);

  logic [XLEN-1:0] regs_q [SIZE];
  logic [XLEN-1:0] regs_d [SIZE];

  logic [AW-1:0]   rd_addr [NREAD];
  logic [AW-1:0]   wr_addr [NWRITE];
  logic [XLEN-1:0] wr_val  [NWRITE];
  logic [NWRITE-1:0] wr_ok;
  logic            freeze;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < SIZE;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  for (genvar i = 0; i < NREAD; i++) begin : g_rd_addr
    assign rd_addr[i] = rd_num[field_lo(i, AW) +: AW];
  end

  for (genvar j = 0; j < NWRITE; j++) begin : g_wr_port
    assign wr_addr[j] = wr_num[field_lo(j, AW) +: AW];
    assign wr_val[j]  = wr_data[field_lo(j, XLEN) +: XLEN];
  end

  // A write is legal only when in range, not to the zero register and not
  // while the snapshot is frozen. The same qualifier gates bypass.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWRITE; j++) begin
      wr_ok[j] = wr_we[j] & in_range(wr_addr[j]) & ~is_zero_reg(wr_addr[j]) & ~freeze;
    end
  end

  always_comb begin
    regs_d = regs_q;
    // Ascending order so the highest-index port wins on address conflicts.
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_ok[j]) begin
        regs_d[wr_addr[j]] = wr_val[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < SIZE; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (in_range(rd_addr[i]) && !is_zero_reg(rd_addr[i])) begin
        rd_data[field_lo(i, XLEN) +: XLEN] = regs_q[rd_addr[i]];
      end
      if (BYPASS != 0) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wr_ok[j] && (wr_addr[j] == rd_addr[i])) begin
            rd_data[field_lo(i, XLEN) +: XLEN] = wr_val[j];
          end
        end
      end
    end
  end

  regfile_dump_fsm #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_dump_fsm (
    .clk        (clk),
    .rst_b      (rst_b),
    .halted     (halted),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_idx   (dump_idx),
    .freeze     (freeze)
  );

  // dump_idx is always < SIZE; gate with valid so idle/reset shows zero.
  assign dump_data = dump_valid ? regs_q[dump_idx] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int SIZE   = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst_b = 1'b0;
  logic [NREAD*AW-1:0]    rd_num = '0;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NWRITE-1:0]      wr_we = '0;
  logic [NWRITE*AW-1:0]   wr_num = '0;
  logic [NWRITE*XLEN-1:0] wr_data = '0;
  logic                   halted = 1'b0;
  logic                   dump_valid;
  logic                   dump_ready = 1'b0;
  logic [AW-1:0]          dump_idx;
  logic [XLEN-1:0]        dump_data;
  logic                   dump_done;

  // Second instance without bypass, single write port, snapshot unused.
  logic [NREAD*XLEN-1:0]  nb_rd_data;
  logic                   nb_dump_valid;
  logic [AW-1:0]          nb_dump_idx;
  logic [XLEN-1:0]        nb_dump_data;
  logic                   nb_dump_done;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .SIZE(SIZE), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_b(rst_b), .rd_num(rd_num), .rd_data(rd_data),
    .wr_we(wr_we), .wr_num(wr_num), .wr_data(wr_data),
    .halted(halted), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );

  regfile_mp #(
    .XLEN(XLEN), .SIZE(SIZE), .NREAD(NREAD), .NWRITE(1), .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .clk(clk), .rst_b(rst_b), .rd_num(rd_num), .rd_data(nb_rd_data),
    .wr_we(wr_we[0:0]), .wr_num(wr_num[AW-1:0]), .wr_data(wr_data[XLEN-1:0]),
    .halted(1'b0), .dump_valid(nb_dump_valid), .dump_ready(1'b0),
    .dump_idx(nb_dump_idx), .dump_data(nb_dump_data), .dump_done(nb_dump_done)
  );

  typedef enum {KRd, KRdNb, KStat} kind_e;
  typedef struct {
    kind_e       kind;
    int          port;
    logic [31:0] val;
    logic        valid;
    logic        done;
    logic [4:0]  idx;
    string       name;
  } exp_t;
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: consumes queued expectations at each falling edge.
  exp_t  m_e;
  beat_t m_b;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      case (m_e.kind)
        KRd:   check(m_e.name, rd_data[m_e.port*XLEN +: XLEN], m_e.val);
        KRdNb: check(m_e.name, nb_rd_data[m_e.port*XLEN +: XLEN], m_e.val);
        default: begin
          check({m_e.name, "_valid"}, 32'(dump_valid), 32'(m_e.valid));
          check({m_e.name, "_done"}, 32'(dump_done), 32'(m_e.done));
          check({m_e.name, "_idx"}, 32'(dump_idx), 32'(m_e.idx));
          check({m_e.name, "_data"}, dump_data, m_e.val);
        end
      endcase
    end
    if (dump_valid) begin
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got idx %0d, expected no beat", dump_idx);
      end else begin
        m_b = beat_q[0];
        // Checked every valid cycle, so a stalled beat must stay stable.
        check("beat_idx", 32'(dump_idx), 32'(m_b.idx));
        check("beat_data", dump_data, m_b.data);
        if (dump_ready) void'(beat_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input kind_e k, input int port, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.port = port; e.val = v; e.valid = 0; e.done = 0; e.idx = 0; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic exp_stat(input logic v, input logic d, input logic [4:0] idx,
                          input logic [31:0] data, input string n);
    exp_t e;
    e.kind = KStat; e.port = 0; e.val = data; e.valid = v; e.done = d; e.idx = idx; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic push_beat(input int idx, input logic [31:0] data);
    beat_t b;
    b.idx = 5'(idx); b.data = data;
    beat_q.push_back(b);
  endtask

  task automatic set_wr(input int p, input logic we, input int addr, input logic [31:0] d);
    wr_we[p] = we;
    wr_num[p*AW +: AW] = AW'(addr);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int addr);
    rd_num[p*AW +: AW] = AW'(addr);
  endtask

  task automatic wait_beats(input bit toggle, input int budget, input string n);
    for (int c = 0; c < budget && beat_q.size() > 0; c++) begin
      if (toggle) dump_ready = ~dump_ready;
      step();
    end
    if (beat_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d beats outstanding, expected 0", n, beat_q.size());
      beat_q.delete();
    end
  endtask

  initial begin
    // Reset state
    set_rd(0, 5);
    step();
    exp_stat(0, 0, 0, 32'h0, "reset_stat");
    exp_rd(KRd, 0, 32'h0, "reset_r5");
    step();
    rst_b = 1'b1;
    step();

    // Plain write then read on port 1
    set_wr(0, 1, 5, 32'hDEADBEEF);
    step();
    set_wr(0, 0, 0, 0);
    set_rd(1, 5);
    exp_rd(KRd, 1, 32'hDEADBEEF, "read_r5");
    step();

    // Zero register: no bypass and no storage
    set_wr(0, 1, 0, 32'h1234);
    set_rd(0, 0);
    exp_rd(KRd, 0, 32'h0, "r0_no_bypass");
    step();
    set_wr(0, 0, 0, 0);
    exp_rd(KRd, 0, 32'h0, "r0_read");
    step();

    // Bypass vs. no bypass
    set_wr(0, 1, 7, 32'hA5A5A5A5);
    set_rd(0, 7);
    exp_rd(KRd, 0, 32'hA5A5A5A5, "bypass_on");
    exp_rd(KRdNb, 0, 32'h0, "bypass_off");
    step();
    set_wr(0, 0, 0, 0);
    exp_rd(KRdNb, 0, 32'hA5A5A5A5, "nb_after_edge");
    step();

    // Write conflict: port 1 wins
    set_wr(0, 1, 3, 32'h11);
    set_wr(1, 1, 3, 32'h22);
    set_rd(0, 3);
    exp_rd(KRd, 0, 32'h22, "conflict_bypass");
    step();
    set_wr(0, 0, 0, 0);
    set_wr(1, 0, 0, 0);
    exp_rd(KRd, 0, 32'h22, "conflict_stored");
    step();

    // Preload rN = N*0x10, two registers per cycle
    for (int n = 0; n < SIZE / 2; n++) begin
      set_wr(0, 1, 2 * n, 32'(2 * n * 'h10));
      set_wr(1, 1, 2 * n + 1, 32'((2 * n + 1) * 'h10));
      step();
    end
    set_wr(0, 0, 0, 0);
    set_wr(1, 0, 0, 0);

    // Dump with backpressure and a frozen write to r9
    for (int n = 0; n < SIZE; n++) push_beat(n, 32'(n * 'h10));
    dump_ready = 1'b0;
    halted = 1'b1;
    step();
    set_wr(0, 1, 9, 32'hFFFF);
    set_rd(0, 9);
    exp_rd(KRd, 0, 32'h90, "freeze_no_bypass");
    exp_stat(1, 0, 0, 32'h0, "first_beat");
    step();
    set_wr(0, 0, 0, 0);
    wait_beats(1'b1, 200, "dump_timeout");
    dump_ready = 1'b1;
    exp_stat(0, 1, 31, 32'h0, "done_set");
    exp_rd(KRd, 0, 32'h90, "freeze_r9");
    step();
    halted = 1'b0;
    exp_stat(0, 1, 31, 32'h0, "done_held");
    step();
    exp_stat(0, 0, 31, 32'h0, "done_clear");
    step();
    set_wr(0, 1, 9, 32'hFFFF);
    step();
    set_wr(0, 0, 0, 0);
    exp_rd(KRd, 0, 32'hFFFF, "r9_after_idle");
    step();

    // Reset in the middle of a dump
    for (int n = 0; n < 4; n++) push_beat(n, 32'(n * 'h10));
    halted = 1'b1;
    step();
    for (int c = 0; c < 50 && !(dump_valid && dump_idx == 5'd4); c++) step();
    if (!(dump_valid && dump_idx == 5'd4)) begin
      checks++;
      errors++;
      $display("FAIL beat4_timeout: got idx %0d, expected 4", dump_idx);
    end
    rst_b = 1'b0;
    set_rd(0, 9);
    set_rd(1, 16);
    exp_stat(0, 0, 0, 32'h0, "abort_stat");
    exp_rd(KRd, 0, 32'h0, "abort_r9");
    exp_rd(KRd, 1, 32'h0, "abort_r16");
    step();
    for (int n = 0; n < SIZE; n++) push_beat(n, 32'h0);
    rst_b = 1'b1;
    step();
    exp_stat(1, 0, 0, 32'h0, "restart_beat0");
    wait_beats(1'b0, 100, "restart_timeout");
    exp_stat(0, 1, 31, 32'h0, "restart_done");
    step();
    halted = 1'b0;
    step();
    exp_stat(0, 0, 31, 32'h0, "restart_idle");
    step();
    step();

    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
